// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue in a FIFO.
// Optional same-cycle lu bypass into an empty FIFO is enabled by defining WBARB_BYPASS_EN.
module wb_write_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [63:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [63:0] lu_data,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [63:0] wd3,
    output logic [31:0] pend_mask
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [4:0]  XZR = 5'd31;

    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [63:0]      data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic wb_take, lu_take, not_empty, head_live, bypass, push, pop;

    // Port arbitration and FIFO handshake
    always_comb begin
        wb_take   = wb_valid && (wb_addr != XZR) && !reset;
        not_empty = (count_q != '0);
        lu_ready  = (count_q < CW'(DEPTH)) && !reset;
        lu_take   = lu_valid && lu_ready && (lu_addr != XZR);
`ifdef WBARB_BYPASS_EN
        bypass    = !not_empty && !wb_take && lu_take;
`else
        bypass    = 1'b0;
`endif
        push      = lu_take && !bypass;
        pop       = not_empty && !wb_take && !reset;
        head_live = not_empty && live_q[head_q];

        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        if (wb_take) begin
            we3 = 1'b1;
            wa3 = wb_addr;
            wd3 = wb_data;
        end else if (bypass) begin
            we3 = 1'b1;
            wa3 = lu_addr;
            wd3 = lu_data;
        end else if (head_live && !reset) begin
            we3 = 1'b1;
            wa3 = addr_q[head_q];
            wd3 = data_q[head_q];
        end
    end

    // Live bits are cleared on pop, so only occupied, un-killed entries contribute
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) pend_mask[addr_q[i]] = 1'b1;
        end
        if (reset) pend_mask = '0;
    end

    // FIFO next state; a wb write kills older queued writes to the same register
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_take && (addr_q[i] == wb_addr)) live_d[i] = 1'b0;
        end
        if (pop) live_d[head_q] = 1'b0;
        if (push) begin
            addr_d[tail_q] = lu_addr;
            data_d[tail_q] = lu_data;
            live_d[tail_q] = !(wb_take && (wb_addr == lu_addr));
        end
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: live bits gate every use
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: expected port writes are queued, a negedge monitor checks them.
module tb_wb_write_arbiter;
    logic        clk, reset;
    logic        wb_valid, lu_valid, lu_ready, we3;
    logic [4:0]  wb_addr, lu_addr, wa3;
    logic [63:0] wb_data, lu_data, wd3;
    logic [31:0] pend_mask;

    typedef struct packed {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    wb_write_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pend_mask(pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the next expected write
    always @(negedge clk) begin
        if (we3 === 1'b1) begin
            if (reset) begin
                chk("we3_in_reset", 64'(we3), 64'd0);
            end else if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got X%0d=%0h expected none", wa3, wd3);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wa3), 64'(e.a));
                chk("wr_data", wd3, e.d);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [63:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        if (v && a != 5'd31) exp_q.push_back('{a: a, d: d});
    endtask

    task automatic lu(input logic v, input logic [4:0] a, input logic [63:0] d);
        lu_valid = v;
        lu_addr  = a;
        lu_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h77;
        lu(1'b1, 5'd4, 64'h44);
        cyc();
        cyc();
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_wa3", 64'(wa3), 64'd0);
        chk("rst_wd3", wd3, 64'd0);
        chk("rst_lu_ready", 64'(lu_ready), 64'd0);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        wb(1'b0, 5'd0, 64'd0);
        lu(1'b0, 5'd0, 64'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("idle_we3", 64'(we3), 64'd0);
        chk("idle_lu_ready", 64'(lu_ready), 64'd1);

        // Zero-latency wb write, then XZR discard
        cyc();
        wb(1'b1, 5'd5, 64'h1234);
        #1;
        chk("wb_we3", 64'(we3), 64'd1);
        chk("wb_wa3", 64'(wa3), 64'd5);
        chk("wb_wd3", wd3, 64'h1234);
        cyc();
        wb(1'b1, 5'd31, 64'hdead);
        #1;
        chk("xzr_we3", 64'(we3), 64'd0);

        // Fill the FIFO behind a busy pipeline
        for (int k = 0; k < 6; k++) begin
            cyc();
            wb(1'b1, 5'd1, 64'h100 + 64'(k));
            if (k < 4) lu(1'b1, 5'(2 + k), 64'(32'h20 + 32'(k) * 32'h10));
            else lu(1'b0, 5'd0, 64'd0);
            #1;
            if (k < 4) chk("fill_lu_ready", 64'(lu_ready), 64'd1);
            else begin
                chk("full_lu_ready", 64'(lu_ready), 64'd0);
                chk("full_pend", 64'(pend_mask), 64'h3C);
            end
        end
        for (int k = 0; k < 4; k++) exp_q.push_back('{a: 5'(2 + k), d: 64'(32'h20 + 32'(k) * 32'h10)});
        for (int k = 0; k < 4; k++) begin
            logic [31:0] m;
            m = 32'h3C;
            cyc();
            wb(1'b0, 5'd0, 64'd0);
            #1;
            chk("drain_we3", 64'(we3), 64'd1);
            chk("drain_pend", 64'(pend_mask), 64'(m & ~((32'd1 << (2 + k)) - 32'd1)));
        end
        cyc();
        #1;
        chk("drained_pend", 64'(pend_mask), 64'd0);
        chk("drained_we3", 64'(we3), 64'd0);

        // WAW kill: queued X7=AA overtaken by wb X7=BB
        cyc();
        wb(1'b1, 5'd1, 64'h1);
        lu(1'b1, 5'd7, 64'hAA);
        cyc();
        wb(1'b1, 5'd7, 64'hBB);
        lu(1'b0, 5'd0, 64'd0);
        #1;
        chk("kill_pend_before", 64'(pend_mask), 64'h80);
        cyc();
        wb(1'b1, 5'd1, 64'h2);
        #1;
        chk("kill_pend_after", 64'(pend_mask), 64'd0);
        cyc();
        wb(1'b0, 5'd0, 64'd0);
        #1;
        chk("kill_pop_we3", 64'(we3), 64'd0);
        cyc();
        #1;
        chk("kill_done_lu_ready", 64'(lu_ready), 64'd1);

        // Same-cycle lu X9 and wb X9: entry dropped silently
        cyc();
        wb(1'b1, 5'd9, 64'h22);
        lu(1'b1, 5'd9, 64'h11);
        #1;
        chk("same_pend", 64'(pend_mask), 64'd0);
        cyc();
        wb(1'b0, 5'd0, 64'd0);
        lu(1'b0, 5'd0, 64'd0);
        #1;
        chk("same_pend_next", 64'(pend_mask), 64'd0);
        chk("same_we3_next", 64'(we3), 64'd0);
        cyc();

        // Reset mid-drain
        for (int k = 0; k < 3; k++) begin
            cyc();
            wb(1'b1, 5'd1, 64'h300 + 64'(k));
            lu(1'b1, 5'(10 + k), 64'(32'hA0 + 32'(k) * 32'h10));
        end
        cyc();
        wb(1'b0, 5'd0, 64'd0);
        lu(1'b0, 5'd0, 64'd0);
        exp_q.push_back('{a: 5'd10, d: 64'hA0});
        #1;
        chk("mid_pend", 64'(pend_mask), 64'h1C00);
        cyc();
        reset = 1'b1;
        #1;
        chk("mrst_we3", 64'(we3), 64'd0);
        chk("mrst_lu_ready", 64'(lu_ready), 64'd0);
        chk("mrst_pend", 64'(pend_mask), 64'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("post_rst_pend", 64'(pend_mask), 64'd0);
        chk("post_rst_we3", 64'(we3), 64'd0);
        chk("post_rst_lu_ready", 64'(lu_ready), 64'd1);
        cyc();
        #1;
        chk("post_rst_we3_2", 64'(we3), 64'd0);

        // lu into an idle, empty arbiter
        cyc();
        lu(1'b1, 5'd12, 64'h99);
`ifdef WBARB_BYPASS_EN
        exp_q.push_back('{a: 5'd12, d: 64'h99});
        #1;
        chk("byp_we3", 64'(we3), 64'd1);
        chk("byp_wa3", 64'(wa3), 64'd12);
        chk("byp_pend", 64'(pend_mask), 64'd0);
        cyc();
        lu(1'b0, 5'd0, 64'd0);
        #1;
        chk("byp_next_we3", 64'(we3), 64'd0);
`else
        #1;
        chk("nobyp_we3", 64'(we3), 64'd0);
        cyc();
        lu(1'b0, 5'd0, 64'd0);
        exp_q.push_back('{a: 5'd12, d: 64'h99});
        #1;
        chk("nobyp_we3_next", 64'(we3), 64'd1);
        chk("nobyp_wa3_next", 64'(wa3), 64'd12);
        chk("nobyp_pend", 64'(pend_mask), 64'h1000);
`endif
        // lu to XZR is discarded
        cyc();
        lu(1'b1, 5'd31, 64'h5);
        #1;
        chk("lu_xzr_we3", 64'(we3), 64'd0);
        cyc();
        lu(1'b0, 5'd0, 64'd0);
        #1;
        chk("lu_xzr_we3_next", 64'(we3), 64'd0);
        chk("lu_xzr_pend", 64'(pend_mask), 64'd0);
        cyc();
        cyc();
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
